// File: rtl/norm16_pkg.sv
// norm16_pkg - shared definitions for the sequential normalizer.
//   state_t      : FSM encoding (IDLE, SHIFT, DONE)
//   OP_LOGICAL   : op_type value selecting leading-zero normalization
//   OP_ARITH     : op_type value selecting redundant-sign-bit normalization
//   WIDTH_DEF    : default operand width
//   CNT_W_DEF    : default shift/restore count width
package norm16_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 6;

  localparam logic OP_LOGICAL = 1'b1;
  localparam logic OP_ARITH   = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/norm16_detect.sv
// norm16_detect - combinational classification of the normalizer working
// register.
// Ports:
//   work    in  WIDTH  working register
//   op_type in  1      1 = logical, 0 = arithmetic
//   norm    out 1      value is already normalized
//   degen   out 1      value can never normalize (0, or all-ones when arithmetic)
//   skip4   out 1      top four bits are redundant, a 4-bit step is safe
module norm16_detect
  import norm16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] work,
  input  logic             op_type,
  output logic             norm,
  output logic             degen,
  output logic             skip4
);

  always_comb begin
    norm  = 1'b0;
    degen = 1'b0;
    skip4 = 1'b0;
    if (op_type == OP_LOGICAL) begin
      degen = ~|work;
      norm  = work[WIDTH-1];
      skip4 = ~|work[WIDTH-1:WIDTH-4];
    end else begin
      degen = (&work) | (~|work);
      norm  = work[WIDTH-1] ^ work[WIDTH-2];
      // Five equal bits at the top means four of them are redundant copies
      // of the sign, so shifting four still leaves a valid sign bit.
      skip4 = (&work[WIDTH-1:WIDTH-5]) | (~|work[WIDTH-1:WIDTH-5]);
    end
  end

endmodule

// File: rtl/norm16_seq.sv
// norm16_seq - sequential normalizer. Shifts the captured operand left one
// bit per cycle until it is normalized, then reports the normalized value,
// the shift count n and the restore count (-n mod 2^CNT_W) that the signed
// shifter needs to undo the normalization.
// Build option: define NORM_FAST_EN to allow 4-bit steps while the top bits
// are redundant; results are identical, only latency shrinks.
// Ports:
//   clk     in  1      rising-edge clock
//   rst     in  1      synchronous active-high reset
//   start   in  1      request, accepted only in IDLE
//   num     in  WIDTH  operand, captured on accepted start
//   op_type in  1      1 = logical (leading zeros), 0 = arithmetic (sign bits)
//   busy    out 1      high in SHIFT and DONE
//   done    out 1      one-cycle pulse, results valid from this cycle
//   o       out WIDTH  normalized value
//   count   out CNT_W  left-shift amount n
//   restore out CNT_W  two's complement of n
//   zero    out 1      degenerate operand flag
module norm16_seq
  import norm16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic             op_type,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] o,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] restore,
  output logic             zero
);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic             op_q;
  logic [CNT_W-1:0] n;

  logic norm;
  logic degen;
  logic skip4;
  logic fast_step;

  norm16_detect #(.WIDTH(WIDTH)) u_detect (
    .work    (work),
    .op_type (op_q),
    .norm    (norm),
    .degen   (degen),
    .skip4   (skip4)
  );

`ifdef NORM_FAST_EN
  assign fast_step = skip4;
`else
  logic unused_skip4;
  assign unused_skip4 = skip4;
  assign fast_step    = 1'b0;
`endif

  // Working register, operand type and shift counter are pure datapath and
  // are always (re)loaded on an accepted start, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      work <= num;
      op_q <= op_type;
      n    <= '0;
    end else if (state == SHIFT && !degen && !norm) begin
      if (fast_step) begin
        work <= {work[WIDTH-5:0], 4'b0000};
        n    <= n + CNT_W'(4);
      end else begin
        work <= {work[WIDTH-2:0], 1'b0};
        n    <= n + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      o       <= '0;
      count   <= '0;
      restore <= '0;
      zero    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          // Degenerate operands are caught before any shift, so work still
          // holds the captured operand here.
          if (degen) begin
            state   <= DONE;
            done    <= 1'b1;
            o       <= work;
            count   <= '0;
            restore <= '0;
            zero    <= 1'b1;
          end else if (norm) begin
            state   <= DONE;
            done    <= 1'b1;
            o       <= work;
            count   <= n;
            restore <= -n;
            zero    <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_norm16_seq.sv
// tb_norm16_seq - directed self-checking bench for norm16_seq.
// Cycle numbering: the edge that accepts start is cycle 0; done is registered
// at edge n+1 and is therefore high during cycle n+2.
module tb_norm16_seq;
  import norm16_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num = 16'h0000;
  logic        op_type = OP_LOGICAL;
  logic        busy;
  logic        done;
  logic [15:0] o;
  logic [5:0]  count;
  logic [5:0]  restore;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef NORM_FAST_EN
  localparam int LAT_0001 = 8;
  localparam int LAT_FFF0 = 7;
`else
  localparam int LAT_0001 = 17;
  localparam int LAT_FFF0 = 13;
`endif

  norm16_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .num     (num),
    .op_type (op_type),
    .busy    (busy),
    .done    (done),
    .o       (o),
    .count   (count),
    .restore (restore),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  // Issues one operation and watches done for a bounded 40 cycles.
  // With spam set, start stays high (with a different operand) through SHIFT
  // and DONE; otherwise num/op_type are scrambled right after capture.
  task automatic do_op(input logic [15:0] v, input logic op, input bit spam,
                       output int first_done, output int pulses);
    @(negedge clk);
    num = v; op_type = op; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (spam) begin
      num = 16'h8000; op_type = OP_LOGICAL;
    end else begin
      start = 1'b0; num = ~v; op_type = ~op;
    end
    first_done = -1;
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        pulses++;
        if (first_done < 0) first_done = k + 1;
      end
      if (spam && first_done >= 0 && k == first_done) start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if ({o, count, restore, zero} !== 29'd0) begin n_fail++; $display("FAIL reset_outputs: got o=%h count=%0d restore=%b zero=%b expected all 0", o, count, restore, zero); end
    rst = 1'b0;
  endtask

  task automatic test_logical_0001();
    int fd, p;
    logic [15:0] back;
    do_op(16'h0001, OP_LOGICAL, 1'b0, fd, p);
    n_checks++; if (o !== 16'h8000) begin n_fail++; $display("FAIL log0001_o: got %h expected 8000", o); end
    n_checks++; if (count !== 6'd15) begin n_fail++; $display("FAIL log0001_count: got %0d expected 15", count); end
    n_checks++; if (restore !== 6'b110001) begin n_fail++; $display("FAIL log0001_restore: got %b expected 110001", restore); end
    n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL log0001_zero: got %b expected 0", zero); end
    n_checks++; if (fd !== LAT_0001) begin n_fail++; $display("FAIL log0001_latency: got %0d expected %0d", fd, LAT_0001); end
    n_checks++; if (p !== 1) begin n_fail++; $display("FAIL log0001_pulses: got %0d expected 1", p); end
    // Logical right shift by -restore undoes the normalization.
    back = o >> (7'd64 - {1'b0, restore});
    n_checks++; if (back !== 16'h0001) begin n_fail++; $display("FAIL log0001_roundtrip: got %h expected 0001", back); end
  endtask

  task automatic test_arith_fff0();
    int fd, p;
    logic signed [15:0] back;
    do_op(16'hFFF0, OP_ARITH, 1'b0, fd, p);
    n_checks++; if (o !== 16'h8000) begin n_fail++; $display("FAIL arFFF0_o: got %h expected 8000", o); end
    n_checks++; if (count !== 6'd11) begin n_fail++; $display("FAIL arFFF0_count: got %0d expected 11", count); end
    n_checks++; if (restore !== 6'b110101) begin n_fail++; $display("FAIL arFFF0_restore: got %b expected 110101", restore); end
    n_checks++; if (fd !== LAT_FFF0) begin n_fail++; $display("FAIL arFFF0_latency: got %0d expected %0d", fd, LAT_FFF0); end
    back = $signed(o) >>> (7'd64 - {1'b0, restore});
    n_checks++; if (back !== 16'hFFF0) begin n_fail++; $display("FAIL arFFF0_roundtrip: got %h expected fff0", back); end
  endtask

  task automatic test_degenerate();
    int fd, p;
    do_op(16'h0000, OP_LOGICAL, 1'b0, fd, p);
    n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL deg0000_zero: got %b expected 1", zero); end
    n_checks++; if ({o, count, restore} !== 28'd0) begin n_fail++; $display("FAIL deg0000_vals: got o=%h count=%0d restore=%b expected 0", o, count, restore); end
    n_checks++; if (fd !== 2) begin n_fail++; $display("FAIL deg0000_latency: got %0d expected 2", fd); end
    do_op(16'hFFFF, OP_ARITH, 1'b0, fd, p);
    n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL degFFFF_zero: got %b expected 1", zero); end
    n_checks++; if (o !== 16'hFFFF) begin n_fail++; $display("FAIL degFFFF_o: got %h expected ffff", o); end
    n_checks++; if ({count, restore} !== 12'd0) begin n_fail++; $display("FAIL degFFFF_counts: got count=%0d restore=%b expected 0", count, restore); end
    n_checks++; if (fd !== 2) begin n_fail++; $display("FAIL degFFFF_latency: got %0d expected 2", fd); end
  endtask

  task automatic test_arith_2000();
    int fd, p;
    do_op(16'h2000, OP_ARITH, 1'b0, fd, p);
    n_checks++; if (o !== 16'h4000) begin n_fail++; $display("FAIL ar2000_o: got %h expected 4000", o); end
    n_checks++; if (count !== 6'd1) begin n_fail++; $display("FAIL ar2000_count: got %0d expected 1", count); end
    n_checks++; if (restore !== 6'b111111) begin n_fail++; $display("FAIL ar2000_restore: got %b expected 111111", restore); end
    n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL ar2000_zero: got %b expected 0", zero); end
    n_checks++; if (fd !== 3) begin n_fail++; $display("FAIL ar2000_latency: got %0d expected 3", fd); end
  endtask

  task automatic test_ignore_start();
    int fd, p;
    do_op(16'h0001, OP_LOGICAL, 1'b1, fd, p);
    n_checks++; if (p !== 1) begin n_fail++; $display("FAIL ignore_pulses: got %0d expected 1", p); end
    n_checks++; if (fd !== LAT_0001) begin n_fail++; $display("FAIL ignore_latency: got %0d expected %0d", fd, LAT_0001); end
    n_checks++; if (o !== 16'h8000 || count !== 6'd15) begin n_fail++; $display("FAIL ignore_result: got o=%h count=%0d expected o=8000 count=15", o, count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy: got %b expected 0", busy); end
  endtask

  task automatic test_mid_reset();
    int fd, p;
    int seen;
    @(negedge clk);
    num = 16'h0001; op_type = OP_LOGICAL; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if ({o, count, restore, zero} !== 29'd0) begin n_fail++; $display("FAIL midrst_outputs: got o=%h count=%0d restore=%b zero=%b expected all 0", o, count, restore, zero); end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_done: got %0d pulses expected 0", seen); end
    do_op(16'h8000, OP_LOGICAL, 1'b0, fd, p);
    n_checks++; if (count !== 6'd0 || o !== 16'h8000) begin n_fail++; $display("FAIL post_rst_result: got o=%h count=%0d expected o=8000 count=0", o, count); end
    n_checks++; if (fd !== 2) begin n_fail++; $display("FAIL post_rst_latency: got %0d expected 2", fd); end
  endtask

  initial begin
    test_reset();
    test_logical_0001();
    test_arith_fff0();
    test_degenerate();
    test_arith_2000();
    test_ignore_start();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/norm16_seq.md
Name: norm16_seq

Overview:
Sequential normalizer; the inverse partner of the 16-bit signed-count shifter.
- Takes a 16-bit operand and shifts it left one bit per cycle until it is normalized.
- Returns the normalized value, the left-shift count, and a 6-bit two's-complement restore count.
- Feeding the restore count to the shifter with the same op_type reproduces the original operand.
- Sits ahead of the shifter in the datapath: leading-zero/sign normalization for scaling and priority logic.

Parameters:
WIDTH, 16, operand width; only 16 is verified.
CNT_W, 6, count width; 2^(CNT_W-1) must exceed WIDTH so that -WIDTH is representable.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only in IDLE
num  input  WIDTH  operand, captured on accepted start
op_type  input  1  1 = logical (leading zeros), 0 = arithmetic (redundant sign bits); captured with num
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse; results valid from this cycle
o  output  WIDTH  normalized value
count  output  CNT_W  left-shift amount n (non-negative)
restore  output  CNT_W  two's complement of n; bit5 set means a right shift in shifter encoding
zero  output  1  degenerate operand: logical 0; arithmetic 0x0000 or 0xFFFF

Behaviour:
- Reset (synchronous, active-high):
  - State returns to IDLE.
  - Outputs o=0, count=0, restore=0, done=0, busy=0, zero=0.
  - A reset mid-operation aborts the operation; no done pulse is issued.
- IDLE: on start=1, capture num and op_type into the working register, clear the shift counter, go to SHIFT. The edge where start is accepted is cycle 0.
- SHIFT: each cycle evaluate the working register.
  - Degenerate (as defined for zero): go to DONE with n=0; o = captured operand unchanged; zero=1.
  - Normalized (logical: bit15=1; arithmetic: bit15 != bit14): go to DONE.
  - Otherwise: working register shifts left by 1 with 0 fill; n increments.
- DONE:
  - done=1 for exactly one cycle.
  - o, count=n, restore=(-n) mod 64 and zero are registered on the entry edge.
  - Next state is IDLE.
- Latency: done is high in cycle n+2 after acceptance (n=0 → cycle 2; max n=15 → cycle 17).
- start is ignored while busy=1, including in DONE; no queuing.
- Outputs hold their values until the next accepted start completes.
- n never exceeds 15; count and restore do not wrap.
- num and op_type changing after capture have no effect.

Optional Feature:
NORM_FAST_EN
- Defined: SHIFT may move 4 bits in one cycle when the top 4 bits are redundant.
  - Logical: bits 15:12 all zero.
  - Arithmetic: bits 15:11 all equal.
  - Otherwise it falls back to 1-bit steps.
  - Final o, count, restore and zero are identical to the undefined build; only latency shrinks (e.g. 0x0001 completes with done at cycle 8).
- Undefined: strictly 1 bit per cycle, latency exactly n+2.

Decomposition:
- Shared package norm16_pkg contains:
  - State enum: IDLE, SHIFT, DONE.
  - Constants OP_LOGICAL=1'b1 and OP_ARITH=1'b0.
  - Default WIDTH and CNT_W.
- One sub-module, norm16_detect: combinational normalized/degenerate/nibble-skip detection from the working register and op_type.
- The FSM, counter and output registers stay in norm16_seq.

Test Plan:
- Logical 0x0001 → o=0x8000, count=15, restore=6'b110001, zero=0, done at cycle 17 (cycle 8 with NORM_FAST_EN).
- Arithmetic 0xFFF0 → o=0x8000, count=11, restore=6'b110101, done at cycle 13. Apply restore with arithmetic right shift → 0xFFF0.
- Arithmetic 0x2000 → o=0x4000, count=1, restore=6'b111111, done at cycle 3.
- Degenerate inputs, each with done at cycle 2:
  - Logical 0x0000 → zero=1, count=0, restore=0, o=0x0000.
  - Arithmetic 0xFFFF → zero=1, count=0, restore=0, o=0xFFFF.
- Start pulses during SHIFT and DONE → ignored. A single done pulse is issued and results are those of the first operand.
- rst asserted mid-SHIFT on logical 0x0001 → next cycle busy=0, done never pulses, all outputs 0. Logical 0x8000 started afterwards → count=0, done at cycle 2.
